// File: rtl/bmp_pixel_unpacker_if.sv
// Word-in / byte-out bus of bmp_pixel_unpacker.
// The slave modport is the unpacker; the master modport is the word source plus byte sink.
interface bmp_pixel_unpacker_if #(
   parameter int FIFO_DEPTH = 4
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic [63:0]      textI;
   logic             textI_vld;
   logic [7:0]       byte_data;
   logic             byte_vld;
   logic             byte_rdy;
   logic             byte_last;
   logic             frame_done;
   logic             overflow;
   logic [LVL_W-1:0] fifo_level;

   modport master (
      output textI, textI_vld, byte_rdy,
      input  byte_data, byte_vld, byte_last, frame_done, overflow, fifo_level
   );

   modport slave (
      input  textI, textI_vld, byte_rdy,
      output byte_data, byte_vld, byte_last, frame_done, overflow, fifo_level
   );
endinterface

// File: rtl/bmp_pixel_unpacker.sv
// Buffers decrypted 64-bit words in a small FIFO and streams them out as bytes with frame framing.
// Define BMP_UNPACK_BIG_ENDIAN_EN to emit the most significant byte of each word first.
module bmp_pixel_unpacker #(
   parameter int FIFO_DEPTH  = 4,
   parameter int FRAME_BYTES = 3072
) (
   input logic                 clk,
   input logic                 resetn,
   bmp_pixel_unpacker_if.slave bus
);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int LVL_W = AW + 1;
   localparam int CNT_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

   typedef enum logic {EMPTY = 1'b0, ACTIVE = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [63:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [2:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             overflow_q, overflow_d;
   logic             frame_done_q, frame_done_d;

   logic             full, xfer, pop, wr, drop, cnt_last;
   logic [2:0]       byte_sel;
   logic [63:0]      head_word;

   // A full FIFO still takes a word when the head word leaves on the same edge.
   assign full     = (level_q == LVL_W'(FIFO_DEPTH));
   assign xfer     = (state_q == ACTIVE) && bus.byte_rdy;
   assign pop      = xfer && (idx_q == 3'd7);
   assign wr       = bus.textI_vld && (!full || pop);
   assign drop     = bus.textI_vld && full && !pop;
   assign cnt_last = (cnt_q == CNT_W'(FRAME_BYTES - 1));

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      overflow_d   = overflow_q | drop;
      frame_done_d = xfer && cnt_last;
      level_d      = level_q + LVL_W'(wr) - LVL_W'(pop);
      if (wr) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (xfer) begin
         idx_d = idx_q + 3'd1;
         cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (wr) state_d = ACTIVE;
         ACTIVE:  if (level_d == '0) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= EMPTY;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         idx_q        <= '0;
         cnt_q        <= '0;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         overflow_q   <= overflow_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Word storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (resetn && wr) begin
         mem_q[wr_ptr_q] <= bus.textI;
      end
   end

`ifdef BMP_UNPACK_BIG_ENDIAN_EN
   assign byte_sel = ~idx_q;
`else
   assign byte_sel = idx_q;
`endif

   assign head_word      = mem_q[rd_ptr_q];
   assign bus.byte_data  = head_word[{byte_sel, 3'b000} +: 8];
   assign bus.byte_vld   = (state_q == ACTIVE);
   assign bus.byte_last  = (state_q == ACTIVE) && cnt_last;
   assign bus.frame_done = frame_done_q;
   assign bus.overflow   = overflow_q;
   assign bus.fifo_level = level_q;
endmodule

// File: tb/tb_bmp_pixel_unpacker.sv
// Directed bench for bmp_pixel_unpacker: a hand-computed vector table plus queue-model sequences.
module tb_bmp_pixel_unpacker;
   localparam int DEPTH = 4;
   localparam int FB    = 12;

   typedef struct {
      logic        rst_n;
      logic        vld;
      logic [63:0] word;
      logic        rdy;
      logic        e_vld;
      logic [7:0]  e_data;
      logic        e_last;
      logic [2:0]  e_lvl;
      logic        e_ovf;
      logic        e_fd;
   } vec_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   bmp_pixel_unpacker_if #(.FIFO_DEPTH(DEPTH)) bus ();

   bmp_pixel_unpacker #(
      .FIFO_DEPTH (DEPTH),
      .FRAME_BYTES(FB)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .bus   (bus)
   );

   int total = 0;
   int bad = 0;

   logic [63:0] mw[$];
   int          midx, fcnt;
   logic        movf, mfd;
   logic [7:0]  last_data;
   int          fd_cnt, xfer_cnt;
   vec_t        vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] get_byte(input logic [63:0] w, input int i);
`ifdef BMP_UNPACK_BIG_ENDIAN_EN
      return w[8*(7-i) +: 8];
`else
      return w[8*i +: 8];
`endif
   endfunction

   function automatic logic [63:0] mkword(input int k);
      logic [63:0] w;
      for (int i = 0; i < 8; i++) w[8*i +: 8] = 8'(k * 16 + i);
      return w;
   endfunction

   task automatic model_clear();
      mw.delete();
      midx = 0;
      fcnt = 0;
      movf = 1'b0;
      mfd  = 1'b0;
   endtask

   task automatic cycle(input logic r, input logic v, input logic [63:0] w, input logic rd);
      logic ev, xf, pp;
      resetn        = r;
      bus.textI_vld = v;
      bus.textI     = w;
      bus.byte_rdy  = rd;
      @(negedge clk);
      ev = (mw.size() > 0);
      chk("byte_vld", bus.byte_vld, ev);
      chk("fifo_level", bus.fifo_level, mw.size());
      chk("overflow", bus.overflow, movf);
      chk("frame_done", bus.frame_done, mfd);
      chk("byte_last", bus.byte_last, ev && (fcnt == FB - 1));
      if (ev) chk("byte_data", bus.byte_data, get_byte(mw[0], midx));
      if (bus.byte_last) last_data = bus.byte_data;
      if (bus.frame_done) fd_cnt++;
      if (bus.byte_vld && bus.byte_rdy) xfer_cnt++;
      @(posedge clk);
      if (!r) begin
         model_clear();
      end else begin
         xf  = ev && rd;
         pp  = xf && (midx == 7);
         mfd = xf && (fcnt == FB - 1);
         if (xf) begin
            fcnt = (fcnt == FB - 1) ? 0 : fcnt + 1;
            if (pp) begin
               void'(mw.pop_front());
               midx = 0;
            end else begin
               midx++;
            end
         end
         if (v) begin
            if (mw.size() < DEPTH) mw.push_back(w);
            else movf = 1'b1;
         end
      end
      #1;
   endtask

   initial begin
      bus.textI     = '0;
      bus.textI_vld = 1'b0;
      bus.byte_rdy  = 1'b0;
      resetn        = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_clear();

      // Single word streamed out with the sink always ready.
      vecs[0] = '{1'b1, 1'b1, 64'h0706_0504_0302_0100, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0};
      for (int k = 1; k <= 8; k++) begin
`ifdef BMP_UNPACK_BIG_ENDIAN_EN
         vecs[k] = '{1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 8'(8 - k), 1'b0, 3'd1, 1'b0, 1'b0};
`else
         vecs[k] = '{1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 8'(k - 1), 1'b0, 3'd1, 1'b0, 1'b0};
`endif
      end
      vecs[9] = '{1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0};

      for (int i = 0; i < 10; i++) begin
         resetn        = vecs[i].rst_n;
         bus.textI_vld = vecs[i].vld;
         bus.textI     = vecs[i].word;
         bus.byte_rdy  = vecs[i].rdy;
         @(negedge clk);
         chk($sformatf("tbl%0d_vld", i), bus.byte_vld, vecs[i].e_vld);
         chk($sformatf("tbl%0d_lvl", i), bus.fifo_level, vecs[i].e_lvl);
         chk($sformatf("tbl%0d_last", i), bus.byte_last, vecs[i].e_last);
         chk($sformatf("tbl%0d_ovf", i), bus.overflow, vecs[i].e_ovf);
         chk($sformatf("tbl%0d_fd", i), bus.frame_done, vecs[i].e_fd);
         if (vecs[i].e_vld) chk($sformatf("tbl%0d_data", i), bus.byte_data, vecs[i].e_data);
         @(posedge clk);
         #1;
      end

      // Overflow: five words into a stalled four-deep FIFO, then drain.
      cycle(1'b0, 1'b0, 64'h0, 1'b0);
      for (int k = 1; k <= 5; k++) cycle(1'b1, 1'b1, mkword(k), 1'b0);
      chk("ovf_level_full", bus.fifo_level, 4);
      chk("ovf_flag_set", bus.overflow, 1'b1);
      repeat (34) cycle(1'b1, 1'b0, 64'h0, 1'b1);
      chk("ovf_drained_level", bus.fifo_level, 0);
      chk("ovf_sticky", bus.overflow, 1'b1);

      // Frame boundary inside the second word.
      cycle(1'b0, 1'b0, 64'h0, 1'b0);
      last_data = 8'hxx;
      fd_cnt    = 0;
      cycle(1'b1, 1'b1, mkword(6), 1'b1);
      cycle(1'b1, 1'b1, mkword(7), 1'b1);
      repeat (16) cycle(1'b1, 1'b0, 64'h0, 1'b1);
      chk("frame_last_byte", last_data, get_byte(mkword(7), 3));
      chk("frame_done_pulses", fd_cnt, 1);

      // Sink readiness toggling every cycle.
      cycle(1'b0, 1'b0, 64'h0, 1'b0);
      xfer_cnt = 0;
      cycle(1'b1, 1'b1, mkword(8), 1'b0);
      for (int j = 0; j < 16; j++) cycle(1'b1, 1'b0, 64'h0, (j % 2) == 0);
      chk("toggle_xfer_count", xfer_cnt, 8);
      chk("toggle_level", bus.fifo_level, 0);

      // Write into a full FIFO while the head word's last byte leaves.
      cycle(1'b0, 1'b0, 64'h0, 1'b0);
      for (int k = 1; k <= 4; k++) cycle(1'b1, 1'b1, mkword(k + 8), 1'b0);
      for (int b = 0; b < 7; b++) cycle(1'b1, 1'b0, 64'h0, 1'b1);
      cycle(1'b1, 1'b1, mkword(13), 1'b1);
      chk("full_pop_level", bus.fifo_level, 4);
      chk("full_pop_ovf", bus.overflow, 1'b0);
      repeat (34) cycle(1'b1, 1'b0, 64'h0, 1'b1);
      chk("full_pop_drained", bus.fifo_level, 0);

      // Reset partway through a word.
      cycle(1'b0, 1'b0, 64'h0, 1'b0);
      cycle(1'b1, 1'b1, mkword(14), 1'b1);
      repeat (3) cycle(1'b1, 1'b0, 64'h0, 1'b1);
      cycle(1'b0, 1'b1, mkword(15), 1'b1);
      chk("rst_mid_vld", bus.byte_vld, 1'b0);
      chk("rst_mid_level", bus.fifo_level, 0);
      last_data = 8'hxx;
      fd_cnt    = 0;
      cycle(1'b1, 1'b1, mkword(1), 1'b1);
      chk("rst_first_byte", bus.byte_data, get_byte(mkword(1), 0));
      cycle(1'b1, 1'b1, mkword(2), 1'b1);
      repeat (16) cycle(1'b1, 1'b0, 64'h0, 1'b1);
      chk("rst_frame_last", last_data, get_byte(mkword(2), 3));
      chk("rst_frame_done", fd_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
